// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX/MEM pipeline register with a 2-entry skid buffer, flush and valid-qualified enables
module ex_mem_stage #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32,
  parameter int LOW_W = 2,
  parameter int SEL_W = 4,
  parameter int REG_W = 5,
  parameter int MEMOP_W = 3,
  parameter int LOADOP_W = 3,
  parameter logic [MEMOP_W-1:0] MEMOP_LOAD = 3'b101,
  parameter logic [MEMOP_W-1:0] MEMOP_STORE = 3'b010,
  parameter int REGEN_BIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic ex_valid,
  output logic ex_ready,
  input  logic [MEMOP_W-1:0] ex_memop,
  input  logic [WORD_W-1:0] ex_result,
  input  logic [ADDR_W-1:0] ex_ramAddr,
  input  logic [SEL_W-1:0] ex_ramSel,
  input  logic [LOADOP_W-1:0] ex_loadop,
  input  logic [REG_W-1:0] ex_regDest,
  output logic mem_valid,
  input  logic mem_ready,
  output logic [MEMOP_W-1:0] mem_memop,
  output logic [WORD_W-1:0] mem_exresult,
  output logic [ADDR_W-LOW_W-1:0] mem_ramAddr,
  output logic [LOW_W-1:0] mem_ramLowAddr,
  output logic [SEL_W-1:0] mem_ramSel,
  output logic [LOADOP_W-1:0] mem_loadop,
  output logic [REG_W-1:0] mem_regDest,
  output logic mem_ramWriteEnable,
  output logic mem_ramReadEnable,
  output logic mem_regWriteEnable,
  output logic [1:0] occupancy
);
  localparam int BW = MEMOP_W + WORD_W + ADDR_W + SEL_W + LOADOP_W + REG_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nx;
  logic rdy_q, in_fire, out_fire, ld_main, ld_skid;
  logic [BW-1:0] main_q, skid_q, ex_b;
  assign ex_b = {ex_memop, ex_result, ex_ramAddr, ex_ramSel, ex_loadop, ex_regDest};
  assign in_fire = ex_valid && rdy_q;
  assign out_fire = mem_valid && mem_ready;
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (in_fire ? ONE : EMPTY) :
               state == ONE ? ((in_fire && !out_fire) ? TWO : (!in_fire && out_fire) ? EMPTY : ONE) :
               (out_fire ? ONE : TWO);
    ld_main = !flush && ((state == EMPTY && in_fire) || (state == ONE && in_fire && out_fire) || (state == TWO && out_fire));
    ld_skid = !flush && state == ONE && in_fire && !out_fire;
  end
  // ex_ready is a flop tracking the next state so it never depends combinationally on mem_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      rdy_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= state_nx != TWO;
      if (flush) main_q <= '0;
      else if (ld_main) main_q <= (state == TWO) ? skid_q : ex_b;
      if (flush) skid_q <= '0;
      else if (ld_skid) skid_q <= ex_b;
    end
  end
  assign {mem_memop, mem_exresult, mem_ramAddr, mem_ramLowAddr, mem_ramSel, mem_loadop, mem_regDest} = main_q;
  assign ex_ready = rdy_q;
  assign mem_valid = state != EMPTY;
  assign occupancy = state;
  assign mem_ramWriteEnable = mem_valid && mem_memop == MEMOP_STORE;
  assign mem_ramReadEnable = mem_valid && mem_memop == MEMOP_LOAD;
  assign mem_regWriteEnable = mem_valid && mem_memop[REGEN_BIT];
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage, default build plus a 64-bit/16-bit-address build on shared handshakes
module tb_ex_mem_stage;
  logic clk = 0, rst = 1, flush = 0, ex_valid = 0, mem_ready = 0;
  logic [2:0] ex_memop = '0, ex_loadop = '0;
  logic [31:0] ex_result = '0, ex_ramAddr = '0;
  logic [3:0] ex_ramSel = '0;
  logic [4:0] ex_regDest = '0;
  logic ex_ready, mem_valid, we, re, rwe;
  logic [2:0] mem_memop, mem_loadop;
  logic [31:0] mem_exresult;
  logic [29:0] mem_ramAddr;
  logic [1:0] mem_ramLowAddr, occupancy;
  logic [3:0] mem_ramSel;
  logic [4:0] mem_regDest;
  logic [63:0] ex_result2;
  logic [15:0] ex_ramAddr2;
  logic ex_ready2, mem_valid2, we2, re2, rwe2;
  logic [2:0] mem_memop2, mem_loadop2, mem_ramLowAddr2;
  logic [63:0] mem_exresult2;
  logic [12:0] mem_ramAddr2;
  logic [1:0] occupancy2;
  logic [3:0] mem_ramSel2;
  logic [4:0] mem_regDest2;
  assign ex_result2 = {ex_result, ~ex_result};
  assign ex_ramAddr2 = ex_ramAddr[15:0];

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_memop(ex_memop), .ex_result(ex_result), .ex_ramAddr(ex_ramAddr), .ex_ramSel(ex_ramSel),
    .ex_loadop(ex_loadop), .ex_regDest(ex_regDest), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_memop(mem_memop), .mem_exresult(mem_exresult), .mem_ramAddr(mem_ramAddr),
    .mem_ramLowAddr(mem_ramLowAddr), .mem_ramSel(mem_ramSel), .mem_loadop(mem_loadop),
    .mem_regDest(mem_regDest), .mem_ramWriteEnable(we), .mem_ramReadEnable(re),
    .mem_regWriteEnable(rwe), .occupancy(occupancy)
  );

  ex_mem_stage #(.ADDR_W(16), .LOW_W(3), .WORD_W(64)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready2),
    .ex_memop(ex_memop), .ex_result(ex_result2), .ex_ramAddr(ex_ramAddr2), .ex_ramSel(ex_ramSel),
    .ex_loadop(ex_loadop), .ex_regDest(ex_regDest), .mem_valid(mem_valid2), .mem_ready(mem_ready),
    .mem_memop(mem_memop2), .mem_exresult(mem_exresult2), .mem_ramAddr(mem_ramAddr2),
    .mem_ramLowAddr(mem_ramLowAddr2), .mem_ramSel(mem_ramSel2), .mem_loadop(mem_loadop2),
    .mem_regDest(mem_regDest2), .mem_ramWriteEnable(we2), .mem_ramReadEnable(re2),
    .mem_regWriteEnable(rwe2), .occupancy(occupancy2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] memop;
    logic [31:0] result;
    logic [31:0] addr;
    logic [3:0] sel;
    logic [2:0] loadop;
    logic [4:0] dest;
  } bun_t;

  bun_t q[$];
  bun_t h;
  bit zeroed = 1;
  logic armed = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // the model may accept input only from the second rising edge after reset release
  always @(posedge clk or negedge rst) armed <= rst;

  always @(negedge clk) begin
    int n;
    logic erdy;
    if (!rst) begin
      chk("rst_ctrl", {mem_valid, occupancy, ex_ready, we, re, rwe}, 0);
      chk("rst_payload", {mem_memop, mem_exresult, mem_ramAddr, mem_ramLowAddr, mem_ramSel, mem_loadop, mem_regDest}, 0);
      chk("rst_ctrl2", {mem_valid2, occupancy2, ex_ready2, we2, re2, rwe2}, 0);
      chk("rst_payload2", {mem_memop2, mem_exresult2, mem_ramAddr2, mem_ramLowAddr2, mem_ramSel2, mem_loadop2, mem_regDest2}, 0);
      q.delete();
      zeroed = 1;
    end else begin
      n = q.size();
      erdy = armed && n < 2;
      chk("ctrl", {mem_valid, occupancy, ex_ready}, {n > 0, 2'(n), erdy});
      chk("ctrl2", {mem_valid2, occupancy2, ex_ready2}, {n > 0, 2'(n), erdy});
      if (n > 0) begin
        h = q[0];
        chk("payload", {mem_memop, mem_exresult, mem_ramAddr, mem_ramLowAddr, mem_ramSel, mem_loadop, mem_regDest},
            {h.memop, h.result, h.addr, h.sel, h.loadop, h.dest});
        chk("payload2", {mem_memop2, mem_exresult2, mem_ramAddr2, mem_ramLowAddr2, mem_ramSel2, mem_loadop2, mem_regDest2},
            {h.memop, h.result, ~h.result, h.addr[15:0], h.sel, h.loadop, h.dest});
        chk("enables", {we, re, rwe, we2, re2, rwe2},
            {h.memop == 3'b010, h.memop == 3'b101, h.memop[0], h.memop == 3'b010, h.memop == 3'b101, h.memop[0]});
      end else begin
        chk("idle_enables", {we, re, rwe, we2, re2, rwe2}, 0);
        if (zeroed) chk("zeroed_payload", {mem_memop, mem_exresult, mem_ramAddr, mem_ramLowAddr, mem_ramSel, mem_loadop, mem_regDest,
                                           mem_memop2, mem_exresult2, mem_ramAddr2, mem_ramLowAddr2}, 0);
      end
      if (n > 0 && mem_ready) void'(q.pop_front());
      if (flush) begin
        q.delete();
        zeroed = 1;
      end else if (ex_valid && erdy) begin
        q.push_back('{ex_memop, ex_result, ex_ramAddr, ex_ramSel, ex_loadop, ex_regDest});
        zeroed = 0;
      end
    end
  end

  task automatic set_bundle(input logic [2:0] op, input logic [31:0] res, input logic [31:0] addr);
    ex_memop = op;
    ex_result = res;
    ex_ramAddr = addr;
    ex_ramSel = 4'($urandom);
    ex_loadop = 3'($urandom);
    ex_regDest = 5'($urandom);
  endtask

  task automatic offer(input logic [2:0] op, input logic [31:0] res, input logic [31:0] addr, input int bound);
    logic acc;
    acc = 0;
    set_bundle(op, res, addr);
    ex_valid = 1;
    for (int i = 0; i < bound && !acc; i++) begin
      acc = ex_ready;
      @(posedge clk);
      #1;
    end
    ex_valid = 0;
    chk("offer_accepted", acc, 1);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #3 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("ready_low_after_release", ex_ready, 0);
    tick();
    chk("ready_rises", ex_ready, 1);
    mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_bundle(3'($urandom), i, $urandom);
      ex_valid = 1;
      chk("stream_ready", ex_ready, 1);
      tick();
      chk("stream_data", {mem_valid, mem_exresult}, {1'b1, 32'(i)});
    end
    ex_valid = 0;
    tick();
    mem_ready = 0;
    offer(3'b101, 32'hA, $urandom, 5);
    offer(3'b010, 32'hB, $urandom, 5);
    chk("bp_full", {occupancy, ex_ready}, {2'd2, 1'b0});
    fork
      offer(3'b001, 32'hC, $urandom, 20);
      begin
        repeat (3) tick();
        mem_ready = 1;
      end
    join
    repeat (4) tick();
    mem_ready = 0;
    offer(3'b011, $urandom, $urandom, 5);
    offer(3'b100, $urandom, $urandom, 5);
    set_bundle(3'b111, 32'hDEAD, $urandom);
    ex_valid = 1;
    flush = 1;
    tick();
    flush = 0;
    ex_valid = 0;
    chk("flush_state", {occupancy, mem_valid, ex_ready}, {2'd0, 1'b0, 1'b1});
    offer(3'b110, $urandom, $urandom, 5);
    set_bundle(3'b101, 32'hBEEF, $urandom);
    ex_valid = 1;
    flush = 1;
    tick();
    flush = 0;
    ex_valid = 0;
    chk("flush_one", {occupancy, mem_valid}, 0);
    offer(3'b101, $urandom, 32'h0000_1236, 5);
    chk("decode_load", {re, we, rwe, mem_ramAddr, mem_ramLowAddr}, {1'b1, 1'b0, 1'b1, 30'h48D, 2'b10});
    chk("decode_load2", {re2, mem_ramAddr2, mem_ramLowAddr2}, {1'b1, 13'h246, 3'b110});
    mem_ready = 1;
    tick();
    mem_ready = 0;
    offer(3'b010, $urandom, 32'h0000_ABCD, 5);
    chk("decode_store", {we, re, rwe}, 3'b100);
    mem_ready = 1;
    tick();
    chk("decode_idle", {mem_valid, we, re, rwe}, 0);
    mem_ready = 0;
    offer(3'b101, $urandom, $urandom, 5);
    offer(3'b010, $urandom, $urandom, 5);
    @(posedge clk);
    #2 rst = 0;
    #1 chk("async_reset", {mem_valid, occupancy, we, re, rwe, mem_exresult, mem_valid2}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("ready_low_after_release2", ex_ready, 0);
    tick();
    chk("ready_rises2", ex_ready, 1);
    repeat (400) begin
      mem_ready = ($urandom % 3) != 0;
      flush = ($urandom % 25) == 0;
      ex_valid = ($urandom % 4) != 0;
      case ($urandom % 4)
        0: set_bundle(3'b101, $urandom, $urandom);
        1: set_bundle(3'b010, $urandom, $urandom);
        default: set_bundle(3'($urandom), $urandom, $urandom);
      endcase
      tick();
    end
    ex_valid = 0;
    flush = 0;
    mem_ready = 1;
    repeat (4) tick();
    chk("drained", {mem_valid, occupancy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
